// File: rtl/cordic_pkg.sv
// Shared widths, gain table and entry layout for the CORDIC result path.
// The gain helper applies a Q0.16 factor with round-half-up.
package cordic_pkg;

    localparam int CORDIC_W = 16;
    localparam int IT_W     = 3;

    // K[k] = prod_{i=0..k} 1/sqrt(1+2^-2i), unsigned Q0.16
    localparam logic [15:0] K_TABLE [0:7] = '{
        16'd46341, 16'd41449, 16'd40211, 16'd39901,
        16'd39823, 16'd39803, 16'd39798, 16'd39797
    };

    typedef struct packed {
        logic signed [CORDIC_W-1:0] x;
        logic signed [CORDIC_W-1:0] y;
        logic signed [CORDIC_W-1:0] deg;
    } entry_t;

    // K < 1, so the rounded product always fits back into 16 bits.
    function automatic logic signed [CORDIC_W-1:0] gain_mul(
        input logic signed [CORDIC_W-1:0] v,
        input logic        [15:0]         k
    );
        logic signed [32:0] p;
        p = 33'(v) * 33'($signed({1'b0, k}));
        p = p + 33'sd32768;
        return p[31:16];
    endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// Circular result queue with drop-on-full and a sticky overflow flag.
// When empty the output holds the last entry popped (zero after reset).
module cordic_result_fifo
    import cordic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     din,
    input  logic                       pop,
    output entry_t                     dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_r [DEPTH];
    entry_t          last_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;
    logic            empty_s;
    logic            full_s;
    logic            do_pop_s;
    logic            do_push_s;
    logic            drop_s;

    // Handshake qualification: a push into a full queue survives only alongside a pop.
    always_comb begin
        empty_s   = (count_r == CW'(0));
        full_s    = (count_r == CW'(DEPTH));
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
        drop_s    = push && full_s && !do_pop_s;
    end

    // Storage, pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            last_r     <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                last_r   <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Head presentation.
    always_comb begin
        if (empty_s) begin
            dout = last_r;
        end else begin
            dout = mem_r[rd_ptr_r];
        end
        valid    = !empty_s;
        count    = count_r;
        overflow = overflow_r;
    end

endmodule

// File: rtl/cordic_result_buffer.sv
// CORDIC output stage: captures results on the termination pulse, applies
// iteration-dependent gain compensation and queues them behind valid/ready.
module cordic_result_buffer
    import cordic_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int GAIN_COMP = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [IT_W-1:0]              numIt_i,
    input  logic                         valid_i,
    input  logic signed [CORDIC_W-1:0]   x_i,
    input  logic signed [CORDIC_W-1:0]   y_i,
    input  logic signed [CORDIC_W-1:0]   deg_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [CORDIC_W-1:0]   x_o,
    output logic signed [CORDIC_W-1:0]   y_o,
    output logic signed [CORDIC_W-1:0]   deg_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         full_o,
    output logic                         overflow_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [IT_W-1:0]             it_r;
    logic                        s1_v_r;
    logic signed [CORDIC_W-1:0]  s1_x_r;
    logic signed [CORDIC_W-1:0]  s1_y_r;
    logic signed [CORDIC_W-1:0]  s1_deg_r;
    logic [15:0]                 s1_k_r;
    entry_t                      s2_entry_s;
    entry_t                      head_s;
    logic [CW-1:0]               count_s;
    logic [CW-1:0]               fill_s;

    // Iteration count of the current job; the capture below reads the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            it_r <= IT_W'(7);
        end else if (start_i) begin
            it_r <= numIt_i;
        end else begin
            it_r <= it_r;
        end
    end

    // S1 capture register, including the gain factor for this job.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r   <= 1'b0;
            s1_x_r   <= '0;
            s1_y_r   <= '0;
            s1_deg_r <= '0;
            s1_k_r   <= '0;
        end else begin
            s1_v_r <= valid_i;
            if (valid_i) begin
                s1_x_r   <= x_i;
                s1_y_r   <= y_i;
                s1_deg_r <= deg_i;
                s1_k_r   <= K_TABLE[it_r];
            end
        end
    end

    // S2 gain stage; the bypass keeps the same two-cycle latency.
    always_comb begin
        s2_entry_s.deg = s1_deg_r;
        if (GAIN_COMP != 0) begin
            s2_entry_s.x = gain_mul(s1_x_r, s1_k_r);
            s2_entry_s.y = gain_mul(s1_y_r, s1_k_r);
        end else begin
            s2_entry_s.x = s1_x_r;
            s2_entry_s.y = s1_y_r;
        end
    end

    cordic_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s1_v_r),
        .din      (s2_entry_s),
        .pop      (out_ready_i),
        .dout     (head_s),
        .valid    (out_valid_o),
        .count    (count_s),
        .overflow (overflow_o)
    );

    // Back-pressure counts the result still sitting in S1.
    always_comb begin
        fill_s  = count_s + CW'(s1_v_r);
        full_o  = (fill_s >= CW'(DEPTH));
        count_o = count_s;
        x_o     = head_s.x;
        y_o     = head_s.y;
        deg_o   = head_s.deg;
    end

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Directed bench for cordic_result_buffer with gain compensation on and off.
module tb_cordic_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  numIt_i;
    logic        valid_i;
    logic [15:0] x_i, y_i, deg_i;
    logic        out_ready_i;

    logic        out_valid_o,  out_valid_b;
    logic [15:0] x_o, y_o, deg_o, x_b, y_b, deg_b;
    logic [2:0]  count_o, count_b;
    logic        full_o, full_b, overflow_o, overflow_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cordic_result_buffer #(.DEPTH(4), .GAIN_COMP(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .numIt_i(numIt_i),
        .valid_i(valid_i), .x_i(x_i), .y_i(y_i), .deg_i(deg_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .x_o(x_o), .y_o(y_o), .deg_o(deg_o), .count_o(count_o),
        .full_o(full_o), .overflow_o(overflow_o)
    );

    cordic_result_buffer #(.DEPTH(4), .GAIN_COMP(0)) dut_nc (
        .clk(clk), .rst(rst), .start_i(start_i), .numIt_i(numIt_i),
        .valid_i(valid_i), .x_i(x_i), .y_i(y_i), .deg_i(deg_i),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_i),
        .x_o(x_b), .y_o(y_b), .deg_o(deg_b), .count_o(count_b),
        .full_o(full_b), .overflow_o(overflow_b)
    );

    // Reference gain: (x*K + 2^15) >>> 16.
    function automatic logic [15:0] gain(input int x, input int k);
        longint p;
        p = longint'(x) * longint'(k) + 64'sd32768;
        return 16'(p >>> 16);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        start_i = 1'b0; valid_i = 1'b0;
    endtask

    task automatic job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] d);
        valid_i = 1'b1; x_i = x; y_i = y; deg_i = d;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; numIt_i = 3'd0; valid_i = 1'b0;
        x_i = 16'd0; y_i = 16'd0; deg_i = 16'd0; out_ready_i = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", {15'd0, out_valid_o}, 16'd0);
        chk("rst_x", x_o, 16'd0);
        chk("rst_count", {13'd0, count_o}, 16'd0);
        chk("rst_full", {15'd0, full_o}, 16'd0);
        chk("rst_ovf", {15'd0, overflow_o}, 16'd0);

        // Single job, numIt = 7
        start_i = 1'b1; numIt_i = 3'd7; tick();
        idle(); job(16'd1000, 16'hFC18, 16'h2D00); tick();
        idle();
        chk("single_lat1", {15'd0, out_valid_o}, 16'd0);
        tick();
        chk("single_valid", {15'd0, out_valid_o}, 16'd1);
        chk("single_x", x_o, 16'd607);
        chk("single_y", y_o, 16'hFDA1);
        chk("single_deg", deg_o, 16'h2D00);
        tick();
        chk("single_drained", {15'd0, out_valid_o}, 16'd0);
        chk("single_count", {13'd0, count_o}, 16'd0);
        chk("single_last_x", x_o, 16'd607);

        // Table index 0, both gain settings
        start_i = 1'b1; numIt_i = 3'd0; tick();
        idle(); job(16'h4000, 16'h4000, 16'h0100); tick();
        idle(); tick();
        chk("tbl_valid", {15'd0, out_valid_o}, 16'd1);
        chk("tbl_x", x_o, 16'd11585);
        chk("tbl_y", y_o, 16'd11585);
        chk("nc_valid", {15'd0, out_valid_b}, 16'd1);
        chk("nc_x", x_b, 16'h4000);
        chk("nc_y", y_b, 16'h4000);
        tick();

        // Fill and stall, jobs spaced by full_o
        out_ready_i = 1'b0;
        start_i = 1'b1; numIt_i = 3'd7; tick();
        idle();
        for (int j = 0; j < 4; j++) begin
            chk("fill_full_before", {15'd0, full_o}, 16'd0);
            job(16'(100 * (j + 1)), 16'(-100 * (j + 1)), 16'(j)); tick();
            idle(); tick();
        end
        chk("fill_count", {13'd0, count_o}, 16'd4);
        chk("fill_full", {15'd0, full_o}, 16'd1);
        chk("fill_ovf", {15'd0, overflow_o}, 16'd0);
        out_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_valid", {15'd0, out_valid_o}, 16'd1);
            chk("drain_x", x_o, gain(100 * (j + 1), 39797));
            chk("drain_y", y_o, gain(-100 * (j + 1), 39797));
            chk("drain_deg", deg_o, 16'(j));
            tick();
        end
        chk("drain_empty", {15'd0, out_valid_o}, 16'd0);

        // Full with simultaneous push and pop
        out_ready_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            job(16'(1000 + j), 16'd0, 16'(j)); tick();
        end
        idle(); tick();
        chk("sim_count_full", {13'd0, count_o}, 16'd4);
        job(16'd2000, 16'd0, 16'h00AA); tick();
        idle(); out_ready_i = 1'b1;
        chk("sim_full_flag", {15'd0, full_o}, 16'd1);
        tick();
        out_ready_i = 1'b0;
        chk("sim_count", {13'd0, count_o}, 16'd4);
        chk("sim_ovf", {15'd0, overflow_o}, 16'd0);
        out_ready_i = 1'b1;
        for (int j = 1; j < 4; j++) begin
            chk("sim_order_x", x_o, gain(1000 + j, 39797));
            tick();
        end
        chk("sim_last_x", x_o, gain(2000, 39797));
        chk("sim_last_deg", deg_o, 16'h00AA);
        tick();
        chk("sim_empty", {15'd0, out_valid_o}, 16'd0);

        // Overflow: five back-to-back results into a stalled queue
        out_ready_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            job(16'(200 * (j + 1)), 16'd0, 16'(j)); tick();
        end
        idle(); tick();
        chk("ovf_count", {13'd0, count_o}, 16'd4);
        chk("ovf_flag", {15'd0, overflow_o}, 16'd1);
        out_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("ovf_order_x", x_o, gain(200 * (j + 1), 39797));
            tick();
        end
        chk("ovf_drained", {15'd0, out_valid_o}, 16'd0);
        chk("ovf_sticky", {15'd0, overflow_o}, 16'd1);

        // Reset one cycle after valid_i
        job(16'd300, 16'd300, 16'd5); tick();
        idle(); rst = 1'b1; tick();
        rst = 1'b0;
        chk("mid_valid", {15'd0, out_valid_o}, 16'd0);
        chk("mid_x", x_o, 16'd0);
        chk("mid_deg", deg_o, 16'd0);
        chk("mid_count", {13'd0, count_o}, 16'd0);
        chk("mid_full", {15'd0, full_o}, 16'd0);
        chk("mid_ovf", {15'd0, overflow_o}, 16'd0);
        tick(); tick();
        chk("mid_no_output", {15'd0, out_valid_o}, 16'd0);

        // Reset restores the iteration count to 7
        job(16'd1000, 16'd0, 16'd0); tick();
        idle(); tick();
        chk("it_reset_x", x_o, 16'd607);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_result_buffer.md
# cordic_result_buffer

Output stage directly downstream of the CORDIC datapath. Captures each finished result (x, y, accumulated angle) on the datapath's one-cycle termination pulse. Applies CORDIC gain compensation selected by the iteration count of that job, and queues results in a small FIFO. Results drain through a valid/ready handshake, and `full_o` back-pressures the controller so it does not start new jobs.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `GAIN_COMP`, 1: 1 = multiply x/y by K(numIt); 0 = pass x/y through unchanged. Latency is identical in both cases.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  same start pulse the datapath receives; latches `numIt_i`.
- `numIt_i`  in  3  iteration count of the job being started.
- `valid_i`  in  1  datapath termination pulse; x/y/deg valid in this cycle.
- `x_i`, `y_i`  in  16  signed datapath results.
- `deg_i`  in  16  signed accumulated angle, Q8.8.
- `out_valid_o`  out  1  FIFO head valid.
- `out_ready_i`  in  1  consumer accepts the head.
- `x_o`, `y_o`  out  16  signed compensated results at the head.
- `deg_o`  out  16  angle at the head.
- `count_o`  out  $clog2(DEPTH)+1  entries in the FIFO.
- `full_o`  out  1  no room for another job (see Operation).
- `overflow_o`  out  1  sticky; a result was dropped.

## Operation

- **Job setup:** `start_i` high → `it_r <= numIt_i`. Reset value of `it_r` is 7.
- **Stage S1 (capture):** `valid_i` high → S1 registers take x_i, y_i, deg_i and K = K_TABLE[it_r], and `s1_v` is set. Otherwise `s1_v` clears. If `start_i` and `valid_i` occur in the same cycle, S1 uses the old `it_r`.
- **Stage S2 (multiply and write):** combinational from S1.
  - Compute p = x·K, a signed 16 × unsigned 16 → 33-bit product.
  - Result = (p + 2^15) >>> 16, i.e. round-half-up.
  - No saturation is needed because K < 1.
  - deg passes through unchanged.
  - When `s1_v` is high, the result is pushed into the FIFO at the next edge.
- **FIFO:** circular buffer of DEPTH entries with read/write pointers and a count.
  - Pop: `out_valid_o && out_ready_i`.
  - Push and pop in the same cycle when full: both happen and the count stays at DEPTH.
  - Push when full without a pop: the entry is dropped and `overflow_o` is set. `overflow_o` is cleared only by `rst`.
  - Pop when empty: ignored.
- **Back-pressure:** `full_o = (count + s1_v) >= DEPTH`. The controller must not assert `start_i` while `full_o` is high. This rule is the only way to prevent drops.
- **Outputs:** `x_o`/`y_o`/`deg_o` show the head entry combinationally. When the FIFO is empty they show the last entry read, or 0 after reset.
- **Reset values:** `out_valid_o`=0, `x_o`/`y_o`/`deg_o`=0, `count_o`=0, `full_o`=0, `overflow_o`=0.
  - Reset mid-operation clears S1, the pointers and the count. Any in-flight results are lost, with no overflow flag.

## Timing

- `valid_i` in cycle t → S1 loaded at edge t→t+1 → FIFO write at edge t+1→t+2.
- `out_valid_o` is high in cycle t+2 if the FIFO was empty. Latency is 2 cycles for both GAIN_COMP values.
- Back-to-back `valid_i` on every cycle is supported, at one result per cycle.
- The handshake is a standard valid/ready:
  - `out_valid_o` does not depend on `out_ready_i`.
  - The head stays stable until it is popped.
- `full_o` updates one cycle after the push or pop that changes it.

## Structure

- Package `cordic_pkg` holds:
  - `K_TABLE[0:7]`, unsigned Q0.16, with K[k] = ∏_{i=0..k} 1/√(1+2^−2i). Values: 46341, 41449, 40211, 39901, 39823, 39803, 39798, 39797.
  - The widths `CORDIC_W = 16` and `IT_W = 3`.
- One sub-module, `cordic_result_fifo`. It holds a DEPTH-entry 48-bit entry {x,y,deg}, with push/pop/count/full/empty and drop-on-full. The gain stage and `it_r` live in the top module.

## Test plan

- **Single job:** start with numIt=7, then `valid_i` with x=1000, y=−1000, deg=16'h2D00 and ready=1.
  - Required: `out_valid_o` high exactly 2 cycles later with x=607, y=−607, deg=16'h2D00.
  - Then `out_valid_o` low and `count_o`=0.
- **Table index:** numIt=0, x=y=16'h4000.
  - Required: x=y=11585.
  - Same stimulus with GAIN_COMP=0: required x=y=16'h4000, same latency.
- **Fill and stall:** ready=0, 4 jobs spaced by `full_o`.
  - Required: `count_o`=4, `full_o`=1, no overflow.
  - Then ready=1: four pops, in order, on consecutive cycles.
- **Overflow:** ready=0, 5 back-to-back `valid_i` while ignoring `full_o`.
  - Required: first 4 kept, 5th dropped, `overflow_o`=1 and sticky through subsequent pops.
- **Full with simultaneous push/pop:** FIFO full, ready=1 and a push in the same cycle.
  - Required: `count_o` stays 4, no overflow, new entry appears last.
- **Reset mid-flight:** `rst` one cycle after `valid_i`.
  - Required: no output appears.
  - All outputs at reset values the next cycle, `overflow_o`=0.
